// File: rtl/mem_arbiter_pkg.sv
// Shared IDs and command fields for the icache/dcache memory-port arbiter.
// Pure declarations: no latency or backpressure of its own.
package mem_arbiter_pkg;

    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

    localparam int unsigned MEM_DW = 32;

    typedef logic req_id_t;

    typedef struct packed {
        logic              ren;
        logic              wen;
        logic [MEM_DW-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/arb_owner_fifo.sv
// 1-bit owner-ID sync FIFO recording which cache issued each outstanding read.
// Head visible combinationally (0 latency); push while full is dropped unless a pop shares the cycle.
module arb_owner_fifo
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_push,
    input  req_id_t i_push_dat,
    input  logic    i_pop,
    output req_id_t o_head_dat,
    output logic    o_full,
    output logic    o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [DEPTH-1:0] mem_q,    mem_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign o_full     = (count_q == CNT_FULL);
    assign o_empty    = (count_q == '0);
    assign o_head_dat = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot the push lands in.
    assign push_ok = i_push & (~o_full | i_pop);
    assign pop_ok  = i_pop & ~o_empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = i_push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin share of one memory port between icache (0) and dcache (1); 0-cycle request path.
// Backpressure: ready only with grant; reads held off while MAX_OUTST reads are outstanding.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned AW        = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_r0_ren,
    input  logic              i_r0_wen,
    input  logic [AW-1:0]     i_r0_addr,
    input  logic [MEM_DW-1:0] i_r0_wdata,
    output logic              o_r0_ready,
    output logic              o_r0_valid,
    input  logic              i_r1_ren,
    input  logic              i_r1_wen,
    input  logic [AW-1:0]     i_r1_addr,
    input  logic [MEM_DW-1:0] i_r1_wdata,
    output logic              o_r1_ready,
    output logic              o_r1_valid,
    output logic [MEM_DW-1:0] o_rdata,
    input  logic              i_mem_ready,
    output logic [AW-1:0]     o_mem_addr,
    output logic              o_mem_ren,
    output logic              o_mem_wen,
    output logic [MEM_DW-1:0] o_mem_wdata,
    input  logic [MEM_DW-1:0] i_mem_rdata,
    input  logic              i_mem_valid,
    output logic              o_err
);

    req_id_t  last_q, last_d;
    logic     err_q,  err_d;

    logic     fifo_full;
    logic     fifo_empty;
    req_id_t  fifo_head;
    logic     fifo_push;
    req_id_t  fifo_push_dat;
    logic     fifo_pop;

    logic     elig0, elig1;
    logic     gnt0,  gnt1;
    mem_cmd_t r0_cmd, r1_cmd, gnt_cmd;

    // Full blocks reads even when a response pops this cycle, keeping the count bounded.
    always_comb begin
        elig0 = i_r0_wen | (i_r0_ren & ~fifo_full);
        elig1 = i_r1_wen | (i_r1_ren & ~fifo_full);
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        if (i_mem_ready) begin
            if (elig0 && elig1) begin
                if (last_q == REQ_DCACHE) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = elig0;
                gnt1 = elig1;
            end
        end
    end

    assign o_r0_ready = gnt0;
    assign o_r1_ready = gnt1;

    always_comb begin
        r0_cmd       = '{ren: i_r0_ren, wen: i_r0_wen, wdata: i_r0_wdata};
        r1_cmd       = '{ren: i_r1_ren, wen: i_r1_wen, wdata: i_r1_wdata};
        gnt_cmd      = '0;
        o_mem_addr   = '0;
        if (gnt0) begin
            gnt_cmd    = r0_cmd;
            o_mem_addr = i_r0_addr;
        end else if (gnt1) begin
            gnt_cmd    = r1_cmd;
            o_mem_addr = i_r1_addr;
        end
        o_mem_ren   = gnt_cmd.ren;
        o_mem_wen   = gnt_cmd.wen;
        o_mem_wdata = gnt_cmd.wdata;
    end

    always_comb begin
        fifo_push     = (gnt0 & i_r0_ren) | (gnt1 & i_r1_ren);
        fifo_push_dat = gnt1 ? REQ_DCACHE : REQ_ICACHE;
        fifo_pop      = i_mem_valid & ~fifo_empty;
        last_d        = last_q;
        if (gnt0) begin
            last_d = REQ_ICACHE;
        end else if (gnt1) begin
            last_d = REQ_DCACHE;
        end
        err_d = err_q | (i_mem_valid & fifo_empty);
    end

    assign o_r0_valid = fifo_pop & (fifo_head == REQ_ICACHE);
    assign o_r1_valid = fifo_pop & (fifo_head == REQ_DCACHE);
    assign o_rdata    = i_mem_rdata;
    assign o_err      = err_q;

    arb_owner_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_owner_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (fifo_push),
        .i_push_dat (fifo_push_dat),
        .i_pop      (fifo_pop),
        .o_head_dat (fifo_head),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_q <= REQ_ICACHE;
            err_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario-driven bench for mem_arbiter: expected read owners queued at accept, checked at return.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        r0_ren, r0_wen, r1_ren, r1_wen;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        r0_ready, r0_valid, r1_ready, r1_valid;
    logic [31:0] rdata;
    logic        mem_ready, mem_ren, mem_wen, mem_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_q[$];

    mem_arbiter #(.MAX_OUTST(4), .AW(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_r0_ren    (r0_ren),
        .i_r0_wen    (r0_wen),
        .i_r0_addr   (r0_addr),
        .i_r0_wdata  (r0_wdata),
        .o_r0_ready  (r0_ready),
        .o_r0_valid  (r0_valid),
        .i_r1_ren    (r1_ren),
        .i_r1_wen    (r1_wen),
        .i_r1_addr   (r1_addr),
        .i_r1_wdata  (r1_wdata),
        .o_r1_ready  (r1_ready),
        .o_r1_valid  (r1_valid),
        .o_rdata     (rdata),
        .i_mem_ready (mem_ready),
        .o_mem_addr  (mem_addr),
        .o_mem_ren   (mem_ren),
        .o_mem_wen   (mem_wen),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_valid (mem_valid),
        .o_err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic idle();
        r0_ren = 0; r0_wen = 0; r0_addr = '0; r0_wdata = '0;
        r1_ren = 0; r1_wen = 0; r1_addr = '0; r1_wdata = '0;
        mem_ready = 0; mem_valid = 0; mem_rdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        tick();
        rst_n = 1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        mem_ready = 1;
        #1;
        n_cmp++; if (r0_ready !== 1'b0) begin n_bad++; $display("FAIL rst_r0_ready got %b want 0", r0_ready); end
        n_cmp++; if (r1_ready !== 1'b0) begin n_bad++; $display("FAIL rst_r1_ready got %b want 0", r1_ready); end
        n_cmp++; if (mem_ren !== 1'b0) begin n_bad++; $display("FAIL rst_mem_ren got %b want 0", mem_ren); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", err); end
        tick();
    endtask

    task automatic test_single_read();
        logic e;
        do_reset();
        mem_ready = 1; r0_ren = 1; r0_addr = 32'h100;
        #1;
        n_cmp++; if (r0_ready !== 1'b1) begin n_bad++; $display("FAIL t1_r0_ready got %b want 1", r0_ready); end
        n_cmp++; if (r1_ready !== 1'b0) begin n_bad++; $display("FAIL t1_r1_ready got %b want 0", r1_ready); end
        n_cmp++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL t1_mem_addr got %h want 100", mem_addr); end
        n_cmp++; if (mem_ren !== 1'b1 || mem_wen !== 1'b0) begin n_bad++; $display("FAIL t1_mem_ren_wen got %b%b want 10", mem_ren, mem_wen); end
        exp_q.push_back(1'b0);
        tick();
        r0_ren = 0; mem_valid = 1; mem_rdata = 32'hCAFEF00D;
        #1;
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL t1_scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if (r0_valid !== (e == 1'b0) || r1_valid !== (e == 1'b1)) begin
                n_bad++; $display("FAIL t1_route got v0=%b v1=%b want owner %b", r0_valid, r1_valid, e);
            end
        end
        n_cmp++; if (rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL t1_rdata got %h want cafef00d", rdata); end
        tick();
        mem_valid = 0;
    endtask

    task automatic test_round_robin();
        logic e;
        logic [31:0] ea;
        do_reset();
        mem_ready = 1; r0_ren = 1; r1_ren = 1; r0_addr = 32'h200; r1_addr = 32'h300;
        for (int i = 0; i < 4; i++) begin
            #1;
            e  = (i % 2 == 0);
            ea = e ? 32'h300 : 32'h200;
            n_cmp++;
            if (r1_ready !== e || r0_ready !== ~e || mem_addr !== ea) begin
                n_bad++; $display("FAIL t2_grant%0d got r0=%b r1=%b addr=%h want owner %b addr=%h", i, r0_ready, r1_ready, mem_addr, e, ea);
            end
            exp_q.push_back(e);
            tick();
        end
        r0_ren = 0; r1_ren = 0;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1; mem_rdata = 32'hD000 + i;
            #1;
            n_cmp++;
            if (exp_q.size() == 0) begin n_bad++; $display("FAIL t2_scoreboard empty at %0d", i); end
            else begin
                e = exp_q.pop_front();
                if (r0_valid !== (e == 1'b0) || r1_valid !== (e == 1'b1)) begin
                    n_bad++; $display("FAIL t2_route%0d got v0=%b v1=%b want owner %b", i, r0_valid, r1_valid, e);
                end
            end
            tick();
        end
        mem_valid = 0;
    endtask

    task automatic test_fifo_full();
        logic e;
        do_reset();
        mem_ready = 1; r0_ren = 1; r0_addr = 32'h500;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (r0_ready !== 1'b1) begin n_bad++; $display("FAIL t3_fill%0d got %b want 1", i, r0_ready); end
            exp_q.push_back(1'b0);
            tick();
        end
        r1_wen = 1; r1_addr = 32'h40; r1_wdata = 32'h12345678;
        #1;
        n_cmp++; if (r0_ready !== 1'b0) begin n_bad++; $display("FAIL t3_full_r0_ready got %b want 0", r0_ready); end
        n_cmp++; if (r1_ready !== 1'b1) begin n_bad++; $display("FAIL t3_wr_ready got %b want 1", r1_ready); end
        n_cmp++;
        if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678) begin
            n_bad++; $display("FAIL t3_wr_port got wen=%b ren=%b addr=%h wdata=%h want 1 0 40 12345678", mem_wen, mem_ren, mem_addr, mem_wdata);
        end
        tick();
        r1_wen = 0; mem_valid = 1; mem_rdata = 32'hA5A50001;
        #1;
        n_cmp++; if (r0_ready !== 1'b0) begin n_bad++; $display("FAIL t3_pop_cycle_r0_ready got %b want 0", r0_ready); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL t3_scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if (r0_valid !== (e == 1'b0) || r1_valid !== (e == 1'b1)) begin
                n_bad++; $display("FAIL t3_route got v0=%b v1=%b want owner %b", r0_valid, r1_valid, e);
            end
        end
        tick();
        mem_valid = 0;
        #1;
        n_cmp++; if (r0_ready !== 1'b1) begin n_bad++; $display("FAIL t3_slot_freed got %b want 1", r0_ready); end
        exp_q.push_back(1'b0);
        tick();
        r0_ren = 0;
    endtask

    task automatic test_push_pop_full();
        logic e;
        do_reset();
        mem_ready = 1; r0_ren = 1; r0_addr = 32'h600;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (r0_ready !== 1'b1) begin n_bad++; $display("FAIL t4_fill%0d got %b want 1", i, r0_ready); end
            exp_q.push_back(1'b0);
            tick();
        end
        r0_ren = 0; r1_ren = 1; r1_addr = 32'h700; mem_valid = 1; mem_rdata = 32'hB0;
        #1;
        n_cmp++; if (r1_ready !== 1'b0) begin n_bad++; $display("FAIL t4_blocked_r1_ready got %b want 0", r1_ready); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL t4_scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if (r0_valid !== (e == 1'b0) || r1_valid !== (e == 1'b1)) begin
                n_bad++; $display("FAIL t4_route got v0=%b v1=%b want owner %b", r0_valid, r1_valid, e);
            end
        end
        tick();
        mem_valid = 0;
        #1;
        n_cmp++; if (r1_ready !== 1'b1 || mem_addr !== 32'h700) begin n_bad++; $display("FAIL t4_next_accept got rdy=%b addr=%h want 1 700", r1_ready, mem_addr); end
        exp_q.push_back(1'b1);
        tick();
        r1_ren = 0; r0_ren = 1;
        #1;
        n_cmp++; if (r0_ready !== 1'b0) begin n_bad++; $display("FAIL t4_refull_r0_ready got %b want 0", r0_ready); end
        tick();
        r0_ren = 0;
        for (int k = 0; k < 5; k++) begin
            mem_valid = 1; mem_rdata = 32'hC000 + k;
            r0_ren = (k == 1);
            #1;
            if (k == 1) begin
                n_cmp++; if (r0_ready !== 1'b1) begin n_bad++; $display("FAIL t4_push_pop_ready got %b want 1", r0_ready); end
            end
            n_cmp++;
            if (exp_q.size() == 0) begin n_bad++; $display("FAIL t4_drain scoreboard empty at %0d", k); end
            else begin
                e = exp_q.pop_front();
                if (r0_valid !== (e == 1'b0) || r1_valid !== (e == 1'b1)) begin
                    n_bad++; $display("FAIL t4_drain%0d got v0=%b v1=%b want owner %b", k, r0_valid, r1_valid, e);
                end
            end
            if (k == 1) exp_q.push_back(1'b0);
            tick();
        end
        mem_valid = 0; r0_ren = 0;
        #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL t4_no_err got %b want 0", err); end
        tick();
    endtask

    task automatic test_mem_stall();
        logic e;
        do_reset();
        mem_ready = 0; r0_ren = 1; r1_ren = 1; r0_addr = 32'h800; r1_addr = 32'h900;
        #1;
        n_cmp++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin n_bad++; $display("FAIL t5_stall_ready got %b%b want 00", r0_ready, r1_ready); end
        n_cmp++;
        if (mem_ren !== 1'b0 || mem_wen !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_bad++; $display("FAIL t5_stall_port got ren=%b wen=%b addr=%h wdata=%h want all 0", mem_ren, mem_wen, mem_addr, mem_wdata);
        end
        tick();
        mem_ready = 1;
        #1;
        n_cmp++; if (r1_ready !== 1'b1 || r0_ready !== 1'b0 || mem_addr !== 32'h900) begin n_bad++; $display("FAIL t5_first got r0=%b r1=%b addr=%h want 0 1 900", r0_ready, r1_ready, mem_addr); end
        exp_q.push_back(1'b1);
        tick();
        r1_ren = 0;
        #1;
        n_cmp++; if (r0_ready !== 1'b1 || mem_addr !== 32'h800) begin n_bad++; $display("FAIL t5_second got r0=%b addr=%h want 1 800", r0_ready, mem_addr); end
        exp_q.push_back(1'b0);
        tick();
        r0_ren = 0;
        for (int i = 0; i < 2; i++) begin
            mem_valid = 1; mem_rdata = 32'hE000 + i;
            #1;
            n_cmp++;
            if (exp_q.size() == 0) begin n_bad++; $display("FAIL t5_scoreboard empty at %0d", i); end
            else begin
                e = exp_q.pop_front();
                if (r0_valid !== (e == 1'b0) || r1_valid !== (e == 1'b1)) begin
                    n_bad++; $display("FAIL t5_route%0d got v0=%b v1=%b want owner %b", i, r0_valid, r1_valid, e);
                end
            end
            tick();
        end
        mem_valid = 0;
    endtask

    task automatic test_err();
        do_reset();
        mem_valid = 1; mem_rdata = 32'hDEAD;
        #1;
        n_cmp++; if (r0_valid !== 1'b0 || r1_valid !== 1'b0) begin n_bad++; $display("FAIL t6_spurious_valid got %b%b want 00", r0_valid, r1_valid); end
        tick();
        mem_valid = 0;
        #1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL t6_err_set got %b want 1", err); end
        tick();
        tick();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL t6_err_sticky got %b want 1", err); end
        mem_ready = 1; r0_ren = 1; r1_ren = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if ((r0_ready ^ r1_ready) !== 1'b1) begin n_bad++; $display("FAIL t6_accept%0d got %b%b want one grant", i, r0_ready, r1_ready); end
            tick();
        end
        r0_ren = 0; r1_ren = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        exp_q.delete();
        #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL t6_err_cleared got %b want 0", err); end
        mem_valid = 1;
        #1;
        n_cmp++; if (r0_valid !== 1'b0 || r1_valid !== 1'b0) begin n_bad++; $display("FAIL t6_flushed got %b%b want 00", r0_valid, r1_valid); end
        tick();
        mem_valid = 0;
        #1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL t6_late_valid_err got %b want 1", err); end
        tick();
    endtask

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_single_read();
        test_round_robin();
        test_fifo_full();
        test_push_pop_full();
        test_mem_stall();
        test_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
